input_skew_feeder: RTL
======================

# input_skew_feeder

Holds one N×N operand tile and transmits it into the left edge of the systolic array as diagonally skewed per-row `valid`/data streams. Row lane r is delayed r cycles, so partial products reach the accumulators on the correct wavefront. It is the transmit end of the same `valid` + 8-bit data protocol that the accumulators receive at the array's output. Tile loading and feeding are separate phases, both controlled by the array controller.

## Interface
Parameters:
- `N`, default 2: array dimension (lanes, tile rows/cols); minimum 2.
- `DATA_W`, default 8: operand width.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0); deassertion is synchronous to `clk` upstream.
- `load_en` input 1: write `load_data` into the tile buffer this cycle.
- `load_row` input $clog2(N): tile row index.
- `load_col` input $clog2(N): tile column index.
- `load_data` input DATA_W: element value.
- `start` input 1: begin feeding the stored tile.
- `a_out` output N*DATA_W: lane r occupies bits [r*DATA_W +: DATA_W].
- `a_valid` output N: per-lane valid.
- `busy` output 1: feed in progress.
- `done` output 1: one-cycle pulse after the last feed step.

## Operation
- Buffer `buf[r][c]` is N×N of DATA_W. `load_en` writes `buf[load_row][load_col]` at the clock edge. Indices ≥ N are dropped.
- States:
  - IDLE → FEED on `start`.
  - FEED holds step counter `t`, 0..2N-2. It advances one per cycle. After step 2N-2 it goes to DONE.
  - DONE → IDLE unconditionally after one cycle.
- Step `t`, lane r:
  - If r ≤ t ≤ r+N-1: `a_valid[r]`=1 and lane data = `buf[r][t-r]`.
  - Otherwise `a_valid[r]`=0 and lane data = 0.
- `start` is accepted in IDLE and in DONE, so back-to-back tiles run with no bubble beyond the DONE cycle. `start` is ignored in FEED.
- `load_en` is ignored while `busy`=1. Loading during DONE or IDLE is allowed.
- `load_en` and `start` in the same accepted cycle: start wins and the load is dropped. Step 0 uses the pre-edge buffer.
- No arithmetic is performed on data. Values pass through bit-exact, including zero elements. A zero with `valid`=1 is a legitimate operand.

## Timing
- Reset (`reset`=0, asynchronous):
  - State → IDLE, `t` → 0, all of `buf` → 0.
  - `a_out`=0, `a_valid`=0, `busy`=0, `done`=0.
- Reset asserted mid-FEED aborts immediately. Outputs clear without waiting for a clock.
- All outputs are registered. If `start` is sampled at edge E0, step 0 values are visible after E0, and step s is visible after E0+s.
- `busy`=1 after E0 through E0+2N-2, so it is high for 2N-1 cycles.
- After E0+2N-1: `busy`=0, `done`=1, and all `a_valid`=0.
- `done` deasserts at the next edge unless a new `start` re-enters FEED. If it does, `done`=0 and step 0 of the new tile is presented after that edge.
- Start-to-first-valid latency: 1 edge. Start-to-done latency: 2N edges.

## Structure
- Shared package `tpu_pkg`:
  - Holds `DATA_W`, `N` defaults and the `feed_state_t` enum (IDLE, FEED, DONE).
  - The accumulator side imports the same package so both ends agree on width.
- One natural sub-module, `feeder_lane`, instantiated N times with lane index r as a parameter. It takes `t`, the FEED flag and row r of the buffer, and produces the next-state lane data and valid.
- The top level holds the FSM, the counter, the buffer and the output registers.

## Test plan
All scenarios use N=2, DATA_W=8.
- **Reset values:** hold `reset`=0 → all outputs 0. Release, load nothing, then `start` → three steps with valid pattern 01, 11, 10 and all data 0x00 → `done` pulse.
- **Basic skew:** load buf = [[1,2],[3,4]], then `start` →
  - step0: lane0=1 v=1, lane1 v=0 data 0.
  - step1: lane0=2, lane1=3, both valid.
  - step2: lane0 v=0, lane1=4.
  - Next cycle `done`=1, `busy`=0.
- **Protected buffer:** during FEED, `load_en` writes 0xFF to (0,0) and `start` is pulsed again. Stream is unchanged, with a single `done`. A second run after the tile finishes still shows lane0 step0 = 1.
- **Back-to-back tiles:** `start` asserted in the DONE cycle → new step0 appears the next cycle, and `done` is a single 1-cycle pulse.
- **Simultaneous load and start:** in IDLE, `load_en` with (0,0)=9 and `start` together → step0 lane0=1 (old value), and a later read-back run also shows 1.
- **Reset mid-feed:** assert `reset` at step1 → outputs go 0 asynchronously. After release, `start` yields all-zero data with the normal valid pattern, since the buffer was cleared.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: definitions shared by both edges of the systolic array.
//   TPU_N       default array dimension (lanes, tile rows/cols)
//   TPU_DATA_W  default operand width on the valid + data lanes
//   feed_state_t  input-feeder phase: IDLE, FEED, DONE
// The accumulator side imports this package too, so both ends agree on width.
package tpu_pkg;

   localparam int TPU_N      = 2;
   localparam int TPU_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FEED = 2'd1,
      DONE = 2'd2
   } feed_state_t;

endpackage

// File: rtl/feeder_lane.sv
// feeder_lane: next-cycle value of one skewed row lane of the input feeder.
//   step   feed step the outputs will present next cycle
//   feed   high when the next cycle is a FEED step
//   row    row R of the tile buffer, column c at [c*DATA_W +: DATA_W]
//   data   lane data for that step (0 when the lane is not valid)
//   valid  lane valid for that step
// Lane R is delayed R steps: it carries row[step-R] for R <= step <= R+N-1.
module feeder_lane
   import tpu_pkg::*;
#(
   parameter int N      = TPU_N,
   parameter int DATA_W = TPU_DATA_W,
   parameter int R      = 0,
   parameter int TW     = 2
) (
   input  logic [TW-1:0]       step,
   input  logic                feed,
   input  logic [N*DATA_W-1:0] row,
   output logic [DATA_W-1:0]   data,
   output logic                valid
);

   // Matching step against every column keeps the element select in range
   // for any N, including non-power-of-two sizes.
   always_comb begin
      data  = '0;
      valid = 1'b0;
      for (int c = 0; c < N; c++) begin
         if (feed && (int'(step) == R + c)) begin
            valid = 1'b1;
            data  = row[c*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/input_skew_feeder.sv
// input_skew_feeder: holds one N x N operand tile and streams it into the
// left edge of the systolic array as diagonally skewed valid/data lanes.
//   clk        rising-edge clock
//   reset      asynchronous, active-low
//   load_en    write load_data into tile[load_row][load_col] (ignored while busy)
//   load_row   tile row index
//   load_col   tile column index
//   load_data  element value
//   start      begin feeding the stored tile (accepted in IDLE and DONE)
//   a_out      lane r data at [r*DATA_W +: DATA_W]
//   a_valid    per-lane valid
//   busy       feed in progress (2N-1 cycles)
//   done       one-cycle pulse after the last feed step
//   state_dbg  current feeder phase (feed_state_t encoding)
//
// Handshake: start is a request sampled at the clock edge; it is taken only
// when the feeder is not in FEED (busy=0), otherwise it is dropped. A load in
// the same cycle as an accepted start is dropped, so step 0 always shows the
// tile as it was before that edge.
module input_skew_feeder
   import tpu_pkg::*;
#(
   parameter int N      = TPU_N,
   parameter int DATA_W = TPU_DATA_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_en,
   input  logic [$clog2(N)-1:0]  load_row,
   input  logic [$clog2(N)-1:0]  load_col,
   input  logic [DATA_W-1:0]     load_data,
   input  logic                  start,
   output logic [N*DATA_W-1:0]   a_out,
   output logic [N-1:0]          a_valid,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            state_dbg
);

   localparam int TW   = $clog2(2*N);
   localparam int LAST = 2*N - 2;

   feed_state_t         state;
   logic [TW-1:0]       t;
   logic [DATA_W-1:0]   tile_buf [N][N];
   logic [N*DATA_W-1:0] row_flat [N];

   logic                accept;
   logic                last_step;
   logic                feed_nxt;
   logic [TW-1:0]       step_nxt;
   logic                load_ok;
   logic [N*DATA_W-1:0] data_nxt;
   logic [N-1:0]        valid_nxt;

   assign state_dbg = state;

   assign accept    = (state != FEED) && start;
   assign last_step = (state == FEED) && (t == TW'(LAST));
   assign feed_nxt  = accept || ((state == FEED) && !last_step);
   // An accepted start only happens outside FEED, so step 0 follows it.
   assign step_nxt  = (state == FEED) ? t + TW'(1) : '0;
   assign load_ok   = load_en && (state != FEED) && !start &&
                      (int'(load_row) < N) && (int'(load_col) < N);

   always_comb begin
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            row_flat[r][c*DATA_W +: DATA_W] = tile_buf[r][c];
         end
      end
   end

   for (genvar r = 0; r < N; r++) begin : g_lane
      feeder_lane #(
         .N      (N),
         .DATA_W (DATA_W),
         .R      (r),
         .TW     (TW)
      ) u_lane (
         .step  (step_nxt),
         .feed  (feed_nxt),
         .row   (row_flat[r]),
         .data  (data_nxt[r*DATA_W +: DATA_W]),
         .valid (valid_nxt[r])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               tile_buf[r][c] <= '0;
            end
         end
      end else if (load_ok) begin
         tile_buf[load_row][load_col] <= load_data;
      end
   end

   // Phase FSM, step counter and registered outputs. Lane outputs are always
   // loaded from the lane logic, which drives zeros outside a FEED step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         t       <= '0;
         a_out   <= '0;
         a_valid <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         a_out   <= data_nxt;
         a_valid <= valid_nxt;
         busy    <= feed_nxt;
         done    <= last_step;
         case (state)
            IDLE, DONE: begin
               t <= '0;
               if (start) begin
                  state <= FEED;
               end else begin
                  state <= IDLE;
               end
            end
            FEED: begin
               if (last_step) begin
                  state <= DONE;
                  t     <= '0;
               end else begin
                  t     <= t + TW'(1);
               end
            end
            default: begin
               state <= IDLE;
               t     <= '0;
            end
         endcase
      end
   end

endmodule
